// File: rtl/bp_bank_load_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bp_ctrl_pkg
// Shared definitions for the backprop bank load controller:
//   - state_t   : controller state encoding (IDLE / LOAD / FULL, 2 bits)
//   - LDCNT_W   : width of the load-duration counter
//   - idx_width : index width for a bank of a given depth (never below 1)
//   - sat_inc   : saturating increment for the load-duration counter
// -----------------------------------------------------------------------------
package bp_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam int LDCNT_W = 16;

    // Index width for a bank of 'depth' registers; a 1-bit minimum keeps
    // the port legal even for degenerate depths.
    function automatic int idx_width(input int depth);
        if (depth > 1) begin
            return $clog2(depth);
        end else begin
            return 1;
        end
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [LDCNT_W-1:0] sat_inc(input logic [LDCNT_W-1:0] v);
        if (v == {LDCNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + LDCNT_W'(1);
        end
    endfunction

endpackage

// File: rtl/bp_bank_load_ctrl_if.sv
// -----------------------------------------------------------------------------
// bp_bank_load_if
// Bundles the upstream word stream, the bank load strobes and the consumer
// handshake of the bank load controller.
//   master modport (producer/consumer side): drives start, abort, in_valid,
//       in_data, bank_ack; observes in_ready, ld_data, ld_en, idx, busy,
//       bank_valid, load_cycles.
//   slave modport (controller side): the mirror image.
// -----------------------------------------------------------------------------
interface bp_bank_load_if #(
    parameter int DEPTH  = 10,
    parameter int IWIDTH = 64,
    parameter int IDXW   = bp_ctrl_pkg::idx_width(DEPTH)
);

    logic                             start;
    logic                             abort;
    logic                             in_valid;
    logic                             in_ready;
    logic [IWIDTH-1:0]                in_data;
    logic [IWIDTH-1:0]                ld_data;
    logic [DEPTH-1:0]                 ld_en;
    logic [IDXW-1:0]                  idx;
    logic                             busy;
    logic                             bank_valid;
    logic                             bank_ack;
    logic [bp_ctrl_pkg::LDCNT_W-1:0]  load_cycles;

    modport master (
        output start, abort, in_valid, in_data, bank_ack,
        input  in_ready, ld_data, ld_en, idx, busy, bank_valid, load_cycles
    );

    modport slave (
        input  start, abort, in_valid, in_data, bank_ack,
        output in_ready, ld_data, ld_en, idx, busy, bank_valid, load_cycles
    );

endinterface

// File: rtl/bp_bank_load_ctrl_onehot_dec.sv
// -----------------------------------------------------------------------------
// bp_onehot_dec
// Binary-to-one-hot decoder with an enable; all outputs are low when en=0.
// Ports:
//   idx    : binary register index
//   en     : decode enable
//   onehot : DEPTH-wide one-hot result (at most one bit set)
// -----------------------------------------------------------------------------
module bp_onehot_dec #(
    parameter int IDXW  = 4,
    parameter int DEPTH = 10
) (
    input  logic [IDXW-1:0]  idx,
    input  logic             en,
    output logic [DEPTH-1:0] onehot
);

    // Compare the index against every bit position; en gates the whole vector.
    always_comb begin
        onehot = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            onehot[i] = en && (idx == IDXW'(i));
        end
    end

endmodule

// File: rtl/bp_bank_load_ctrl.sv
// -----------------------------------------------------------------------------
// bp_bank_load_ctrl
// Sequences word-serial loading of a bank of DEPTH enable-only holding
// registers from one upstream stream, then presents the bank as valid to the
// consuming backprop stage until it is acknowledged.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : bp_bank_load_if.slave (start/abort, in_valid/in_ready/in_data,
//         ld_data/ld_en/idx, busy, bank_valid/bank_ack, load_cycles)
// Configuration:
//   BP_BANK_LOAD_CNT_EN : when defined, load_cycles reports the number of
//   cycles spent in LOAD (stalls included) for the most recent completed
//   load; otherwise load_cycles is tied to zero.
// -----------------------------------------------------------------------------
module bp_bank_load_ctrl
    import bp_ctrl_pkg::*;
#(
    parameter int DEPTH  = 10,
    parameter int IWIDTH = 64,
    parameter int IDXW   = idx_width(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    bp_bank_load_if.slave  bus
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [IDXW-1:0]   idx_r;
    logic [IDXW-1:0]   idx_nxt_s;
    logic              bank_valid_r;
    logic              bank_valid_nxt_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              dec_en_s;
    logic [DEPTH-1:0]  ld_en_s;
    logic [IWIDTH-1:0] data_s;

    // abort and rst both mask in_ready so no word is taken in those cycles.
    assign in_ready_s = (state_r == LOAD) && !bus.abort && !rst;
    assign accept_s   = bus.in_valid && in_ready_s;
    assign dec_en_s   = accept_s && !rst;

    bp_onehot_dec #(
        .IDXW  (IDXW),
        .DEPTH (DEPTH)
    ) u_dec (
        .idx    (idx_r),
        .en     (dec_en_s),
        .onehot (ld_en_s)
    );

    // The bank captures in_data directly on the accept edge.
    assign data_s         = bus.in_data;
    assign bus.ld_data    = data_s;
    assign bus.ld_en      = ld_en_s;
    assign bus.in_ready   = in_ready_s;
    assign bus.idx        = idx_r;
    assign bus.busy       = (state_r != IDLE);
    assign bus.bank_valid = bank_valid_r;

    // State, index and bank-valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            idx_r        <= {IDXW{1'b0}};
            bank_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            idx_r        <= idx_nxt_s;
            bank_valid_r <= bank_valid_nxt_s;
        end
    end

    // Next-state logic; abort outranks an accept in LOAD.
    always_comb begin
        state_nxt_s      = state_r;
        idx_nxt_s        = idx_r;
        bank_valid_nxt_s = bank_valid_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_nxt_s = LOAD;
                    idx_nxt_s   = {IDXW{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                if (bus.abort) begin
                    state_nxt_s = IDLE;
                    idx_nxt_s   = {IDXW{1'b0}};
                end else if (accept_s) begin
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s      = FULL;
                        idx_nxt_s        = {IDXW{1'b0}};
                        bank_valid_nxt_s = 1'b1;
                    end else begin
                        idx_nxt_s = idx_r + IDXW'(1);
                    end
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            FULL: begin
                if (bus.bank_ack) begin
                    bank_valid_nxt_s = 1'b0;
                    idx_nxt_s        = {IDXW{1'b0}};
                    // A start alongside the ack reloads without an IDLE bubble.
                    if (bus.start) begin
                        state_nxt_s = LOAD;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: begin
                state_nxt_s      = IDLE;
                idx_nxt_s        = {IDXW{1'b0}};
                bank_valid_nxt_s = 1'b0;
            end
        endcase
    end

`ifdef BP_BANK_LOAD_CNT_EN
    logic [LDCNT_W-1:0] cnt_r;
    logic [LDCNT_W-1:0] load_cycles_r;
    logic               load_done_s;

    assign load_done_s     = (state_r == LOAD) && (state_nxt_s == FULL);
    assign bus.load_cycles = load_cycles_r;

    // Cycle counter: held at zero outside LOAD so every entry starts from
    // zero; the completed count (this cycle included) is latched on LOAD->FULL.
    // An abort leaves load_cycles_r untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r         <= {LDCNT_W{1'b0}};
            load_cycles_r <= {LDCNT_W{1'b0}};
        end else begin
            if (state_r == LOAD) begin
                cnt_r <= sat_inc(cnt_r);
            end else begin
                cnt_r <= {LDCNT_W{1'b0}};
            end
            if (load_done_s) begin
                load_cycles_r <= sat_inc(cnt_r);
            end else begin
                load_cycles_r <= load_cycles_r;
            end
        end
    end
`else
    assign bus.load_cycles = {LDCNT_W{1'b0}};
`endif

endmodule
